overlay_control_hls_deadlock_reporter: RTL and testbench

OVERLAY_CONTROL_HLS_DEADLOCK_REPORTER -- requirements
Module: overlay_control_hls_deadlock_reporter

---
 rtl/overlay_control_hls_deadlock_pkg.sv | 13 +
 rtl/overlay_control_hls_deadlock_satcnt.sv | 41 ++++
 rtl/overlay_control_hls_deadlock_reporter.sv | 149 ++++++++++++++
 tb/tb_overlay_control_hls_deadlock_reporter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_control_hls_deadlock_pkg.sv
// rtl/overlay_control_hls_deadlock_pkg.sv - shared types and constants for the deadlock reporter
package overlay_control_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_REPORT  = 2'd3
    } dl_state_e;

    localparam int REPORT_COUNT_W = 8;

endpackage

// File: rtl/overlay_control_hls_deadlock_satcnt.sv
// rtl/overlay_control_hls_deadlock_satcnt.sv - saturating up-counter with load-to-one
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset (count -> 0)
//   load_one     : restart the count at 1 (takes priority over inc)
//   inc          : increment by one, holding at all-ones
//   count        : current count
module overlay_control_hls_deadlock_satcnt #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_COUNT = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_one) begin
            count_d = W'(1);
        end else if (inc && (count_q != MAX_COUNT)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/overlay_control_hls_deadlock_reporter.sv
// rtl/overlay_control_hls_deadlock_reporter.sv - confirms HLS deadlock-monitor blocks and emits one report per event
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   block           : deadlock-monitor block indication
//   axis_block_info : per-channel block encoding, OR-accumulated over the event
//   clear_flag      : pulse clearing the sticky deadlock_flag (a same-cycle set wins)
//   deadlock_flag   : sticky confirmed-deadlock indicator
//   report_valid/report_ready : record handshake
//   report_info     : OR of all block info seen during the event
//   report_cycles   : cycles block was high during the event, saturating
//   report_count    : number of accepted reports, saturating
module overlay_control_hls_deadlock_reporter
    import overlay_control_hls_deadlock_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 32,
    parameter int INFO_W         = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      block,
    input  logic [INFO_W-1:0]         axis_block_info,
    input  logic                      clear_flag,
    output logic                      deadlock_flag,
    output logic                      report_valid,
    input  logic                      report_ready,
    output logic [INFO_W-1:0]         report_info,
    output logic [CNT_W-1:0]          report_cycles,
    output logic [REPORT_COUNT_W-1:0] report_count
);

    localparam logic [7:0] CONFIRM_TARGET = 8'(CONFIRM_CYCLES);

    dl_state_e         state_q, state_d;
    logic [7:0]        confirm_q, confirm_d;
    logic [INFO_W-1:0] info_q, info_d;
    logic              flag_q, flag_d;

    logic dur_load;
    logic dur_inc;
    logic rpt_inc;
    logic set_flag;

    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        info_d    = info_q;
        dur_load  = 1'b0;
        dur_inc   = 1'b0;
        rpt_inc   = 1'b0;
        set_flag  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (block) begin
                    confirm_d = 8'd1;
                    info_d    = axis_block_info;
                    dur_load  = 1'b1;
                    // A one-sample confirmation window skips CONFIRM entirely.
                    if (CONFIRM_TARGET == 8'd1) begin
                        state_d  = ST_BLOCKED;
                        set_flag = 1'b1;
                    end else begin
                        state_d = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                if (block) begin
                    confirm_d = confirm_q + 8'd1;
                    info_d    = info_q | axis_block_info;
                    dur_inc   = 1'b1;
                    if ((confirm_q + 8'd1) == CONFIRM_TARGET) begin
                        state_d  = ST_BLOCKED;
                        set_flag = 1'b1;
                    end
                end else begin
                    // Short glitch: drop it silently.
                    state_d = ST_IDLE;
                end
            end
            ST_BLOCKED: begin
                if (block) begin
                    info_d  = info_q | axis_block_info;
                    dur_inc = 1'b1;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // Accumulator and duration stay frozen; block is ignored here.
                if (report_ready) begin
                    state_d = ST_IDLE;
                    rpt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (set_flag) begin
            flag_d = 1'b1;
        end else if (clear_flag) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            confirm_q <= '0;
            info_q    <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            confirm_q <= confirm_d;
            info_q    <= info_d;
            flag_q    <= flag_d;
        end
    end

    overlay_control_hls_deadlock_satcnt #(
        .W (CNT_W)
    ) u_duration_cnt (
        .clock    (clock),
        .reset    (reset),
        .load_one (dur_load),
        .inc      (dur_inc),
        .count    (report_cycles)
    );

    overlay_control_hls_deadlock_satcnt #(
        .W (REPORT_COUNT_W)
    ) u_report_cnt (
        .clock    (clock),
        .reset    (reset),
        .load_one (1'b0),
        .inc      (rpt_inc),
        .count    (report_count)
    );

    assign deadlock_flag = flag_q;
    assign report_valid  = (state_q == ST_REPORT);
    assign report_info   = info_q;

endmodule

// File: tb/tb_overlay_control_hls_deadlock_reporter.sv
// tb/tb_overlay_control_hls_deadlock_reporter.sv - self-checking bench for the deadlock reporter
module tb_overlay_control_hls_deadlock_reporter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       block = 1'b0;
    logic [3:0] axis_block_info = 4'h0;
    logic       clear_flag = 1'b0;
    logic       deadlock_flag;
    logic       report_valid;
    logic       report_ready = 1'b0;
    logic [3:0] report_info;
    logic [3:0] report_cycles;
    logic [7:0] report_count;

    int checks   = 0;
    int failures = 0;
    int rpt_model = 0;

    typedef struct {
        logic [3:0] info;
        logic [3:0] cycles;
    } rec_t;

    typedef struct {
        int         n;
        logic [3:0] a;
        logic [3:0] b;
        int         sw;
        bit         exp_rpt;
        logic [3:0] exp_info;
        logic [3:0] exp_cycles;
        bit         exp_flag;
    } vec_t;

    rec_t exp_q[$];
    vec_t vecs[6];

    always #5 clock = ~clock;

    overlay_control_hls_deadlock_reporter #(
        .CONFIRM_CYCLES (4),
        .CNT_W          (4),
        .INFO_W         (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (axis_block_info),
        .clear_flag      (clear_flag),
        .deadlock_flag   (deadlock_flag),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_info     (report_info),
        .report_cycles   (report_cycles),
        .report_count    (report_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_event(input int n, input logic [3:0] a, input logic [3:0] b, input int sw);
        for (int i = 0; i < n; i++) begin
            block = 1'b1;
            axis_block_info = (i < sw) ? a : b;
            step();
        end
        block = 1'b0;
        axis_block_info = 4'h0;
        step();
    endtask

    task automatic handshake();
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        if (rpt_model < 255) rpt_model++;
    endtask

    task automatic expect_report(input string tag);
        rec_t r;
        int waited = 0;
        while (!report_valid && waited < 8) begin
            step();
            waited++;
        end
        check({tag, "_valid"}, report_valid, 1);
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_queue actual=empty expected=record", tag);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_info"}, report_info, r.info);
            check({tag, "_cycles"}, report_cycles, r.cycles);
        end
        handshake();
        check({tag, "_valid_drop"}, report_valid, 0);
        check({tag, "_count"}, report_count, rpt_model);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        bit seen;

        vecs[0] = '{3,  4'hE, 4'hE, 3,  1'b0, 4'h0, 4'h0, 1'b0};
        vecs[1] = '{10, 4'hE, 4'hE, 10, 1'b1, 4'hE, 4'hA, 1'b1};
        vecs[2] = '{10, 4'hE, 4'hB, 5,  1'b1, 4'hF, 4'hA, 1'b1};
        vecs[3] = '{20, 4'h1, 4'h1, 20, 1'b1, 4'h1, 4'hF, 1'b1};
        vecs[4] = '{4,  4'h2, 4'h4, 2,  1'b1, 4'h6, 4'h4, 1'b1};
        vecs[5] = '{1,  4'h8, 4'h8, 1,  1'b0, 4'h0, 4'h0, 1'b0};

        step();
        step();
        check("reset_flag", deadlock_flag, 0);
        check("reset_valid", report_valid, 0);
        check("reset_count", report_count, 0);
        check("reset_cycles", report_cycles, 0);
        #4 reset = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            clear_flag = 1'b1;
            step();
            clear_flag = 1'b0;
            run_event(vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].sw);
            if (vecs[v].exp_rpt) exp_q.push_back('{vecs[v].exp_info, vecs[v].exp_cycles});
            check($sformatf("vec%0d_flag", v), deadlock_flag, vecs[v].exp_flag);
            if (vecs[v].exp_rpt) begin
                expect_report($sformatf("vec%0d", v));
            end else begin
                seen = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    if (report_valid) seen = 1'b1;
                    step();
                end
                check($sformatf("vec%0d_no_report", v), seen, 0);
            end
        end

        // Flag must rise exactly on the 4th high edge.
        clear_flag = 1'b1;
        step();
        clear_flag = 1'b0;
        block = 1'b1;
        axis_block_info = 4'hE;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) check("confirm_edge3_flag", deadlock_flag, 0);
            if (i == 4) check("confirm_edge4_flag", deadlock_flag, 1);
        end
        block = 1'b0;
        step();
        exp_q.push_back('{4'hE, 4'hA});

        // Report held while consumer stalls and block keeps pulsing.
        seen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            block = i[0] ? 1'b0 : 1'b1;
            axis_block_info = 4'h1;
            step();
            if (!(report_valid === 1'b1 && report_info === exp_q[0].info &&
                  report_cycles === exp_q[0].cycles)) seen = 1'b0;
        end
        check("stall_stable", seen, 1);
        r = exp_q.pop_front();
        check("stall_info", report_info, r.info);
        check("stall_cycles", report_cycles, r.cycles);

        // block high during the handshake cycle must not start the next event.
        block = 1'b1;
        axis_block_info = 4'h3;
        handshake();
        check("stall_count", report_count, rpt_model);
        check("handshake_idle_flag", deadlock_flag, 1);
        for (int i = 1; i <= 4; i++) begin
            clear_flag = (i == 4);
            step();
        end
        clear_flag = 1'b0;
        check("set_beats_clear", deadlock_flag, 1);
        block = 1'b0;
        axis_block_info = 4'h0;
        step();
        exp_q.push_back('{4'h3, 4'h4});
        expect_report("after_handshake");

        // Asynchronous reset while blocked.
        run_event(0, 4'h0, 4'h0, 0);
        block = 1'b1;
        axis_block_info = 4'h5;
        for (int i = 0; i < 6; i++) step();
        #2 reset = 1'b1;
        #1;
        check("async_flag", deadlock_flag, 0);
        check("async_valid", report_valid, 0);
        check("async_info", report_info, 0);
        check("async_cycles", report_cycles, 0);
        check("async_count", report_count, 0);
        rpt_model = 0;
        exp_q.delete();
        block = 1'b0;
        axis_block_info = 4'h0;
        step();
        #2 reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (report_valid) seen = 1'b1;
        end
        check("post_reset_no_report", seen, 0);
        check("post_reset_flag", deadlock_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
